ahb_lite_master: RTL

- AHB-Lite initiator that turns a simple valid/ready command port into pipelined single NONSEQ transfers on the system bus.
- Intended to drive our AHB-Lite slaves, such as the on-chip SRAM controller, from DMA engines, debug loaders and test masters.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N, handles HREADY wait states, and implements the two-cycle ERROR response with cancel-and-reissue.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_lite_master.sv | 93 +++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the stage-A command record used by the master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } a_cmd_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands become pipelined single NONSEQ
// transfers, with wait-state stalls and two-cycle ERROR cancel-and-reissue.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [2:0]       cmd_size,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic [1:0]       HRESP
);

  logic        a_vld;
  a_cmd_t      a_q;
  logic        d_vld;
  logic        d_write;
  logic [31:0] d_wdata;

  logic err, accept, d_done, a_adv;
  logic unused_hresp;

  assign unused_hresp = HRESP[1];

  // ERROR seen in the data phase cancels the pending address phase at once.
  assign err    = d_vld & HRESP[0];
  assign d_done = d_vld & HREADY;
  assign a_adv  = a_vld & HREADY & ~err;

  assign cmd_ready = ~a_vld | (HREADY & ~err);
  assign accept    = cmd_valid & cmd_ready;

  assign HTRANS = (a_vld & ~err) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = a_q.addr;
  assign HSIZE  = a_q.size;
  assign HWRITE = a_q.write;
  assign HWDATA = d_vld ? d_wdata : 32'h0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_vld     <= 1'b0;
      a_q       <= '0;
      d_vld     <= 1'b0;
      d_write   <= 1'b0;
      d_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      rsp_valid <= d_done;
      rsp_rdata <= (d_done & ~d_write) ? HRDATA : 32'h0;
      rsp_err   <= d_done & HRESP[0];

      if (HREADY) d_vld <= a_adv;
      if (a_adv) begin
        d_write <= a_q.write;
        d_wdata <= a_q.wdata;
      end

      // An empty A may load even during a stall; a full A only empties when it advances.
      if (accept) begin
        a_vld       <= 1'b1;
        a_q.write   <= cmd_write;
        a_q.addr    <= cmd_addr;
        a_q.size    <= cmd_size;
        a_q.wdata   <= cmd_wdata;
      end else if (a_adv) begin
        a_vld <= 1'b0;
      end

      if (d_done & err & (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

endmodule
